// File: rtl/cardinal_pkg.sv
// ============================================================================
// cardinal_pkg : shared constants for the Cardinal ring CMP NIC
// Rev 1.0
// ============================================================================
`default_nettype none

package cardinal_pkg;

   localparam int DATA_WIDTH = 64;

   typedef logic [1:0] nic_addr_t;

   localparam nic_addr_t NIC_IN_BUF   = 2'b00;
   localparam nic_addr_t NIC_IN_STAT  = 2'b01;
   localparam nic_addr_t NIC_OUT_BUF  = 2'b10;
   localparam nic_addr_t NIC_OUT_STAT = 2'b11;

   // Packet fields use [0:DATA_WIDTH-1] ordering, bit 0 is the MSB
   localparam int PKT_VC_BIT      = 0;
   localparam int PKT_DIR_BIT     = 1;
   localparam int PKT_HOP_LO      = 8;
   localparam int PKT_HOP_HI      = 15;
   localparam int PKT_SRC_LO      = 16;
   localparam int PKT_SRC_HI      = 31;
   localparam int PKT_PAYLOAD_LO  = 32;
   localparam int PKT_PAYLOAD_HI  = 63;

endpackage

`default_nettype wire

// File: rtl/cardinal_nic_if.sv
// ============================================================================
// cardinal_nic_if : processor NIC bus plus router channel signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface cardinal_nic_if #(
   parameter int DATA_WIDTH = 64
);
   logic [1:0]              addr;
   logic [0:DATA_WIDTH-1]   d_in;
   logic [0:DATA_WIDTH-1]   d_out;
   logic                    nicEn;
   logic                    nicWrEn;
   logic                    net_si;
   logic                    net_ri;
   logic [0:DATA_WIDTH-1]   net_di;
   logic                    net_so;
   logic                    net_ro;
   logic [0:DATA_WIDTH-1]   net_do;
   logic                    net_polarity;

   // master: processor and router side; slave: the NIC
   modport master (
      output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
      input  d_out, net_ri, net_so, net_do
   );

   modport slave (
      input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
      output d_out, net_ri, net_so, net_do
   );
endinterface

`default_nettype wire

// File: rtl/nic_chan_buf.sv
// ============================================================================
// nic_chan_buf : single-entry channel buffer with full flag
// Rev 1.0
// ============================================================================
`default_nettype none

module nic_chan_buf #(
   parameter int DATA_WIDTH = 64
) (
   input  wire logic                  CLK,
   input  wire logic                  RESET,
   input  wire logic                  i_load,
   input  wire logic                  i_clear,
   input  wire logic [0:DATA_WIDTH-1] i_data,
   output logic                       o_full,
   output logic [0:DATA_WIDTH-1]      o_data
);

   logic                  r_full;
   logic [0:DATA_WIDTH-1] r_data;

   // Load only happens while empty, so load and clear never collide
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (i_load) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end
   end

   assign o_full = r_full;
   assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/cardinal_nic.sv
// ============================================================================
// cardinal_nic : polled NIC joining a Cardinal node to its ring router port
// Rev 1.0
// ============================================================================
`default_nettype none

module cardinal_nic
   import cardinal_pkg::*;
#(
   parameter int DATA_WIDTH = cardinal_pkg::DATA_WIDTH,
   parameter int VC_BIT     = PKT_VC_BIT
) (
   input  wire logic      CLK,
   input  wire logic      RESET,
   cardinal_nic_if.slave  bus
);

   logic                  w_rd;
   logic                  w_in_load;
   logic                  w_in_clear;
   logic                  w_in_full;
   logic [0:DATA_WIDTH-1] w_in_data;
   logic                  w_out_load;
   logic                  w_out_full;
   logic [0:DATA_WIDTH-1] w_out_data;
   logic                  w_inject;
   logic [0:DATA_WIDTH-1] w_rd_data;
   logic                  r_net_so;
   logic [0:DATA_WIDTH-1] r_net_do;

   assign w_rd       = bus.nicEn & ~bus.nicWrEn;
   assign w_in_load  = bus.net_si & ~w_in_full;
   assign w_in_clear = w_rd & (bus.addr == NIC_IN_BUF);
   assign w_out_load = bus.nicEn & bus.nicWrEn & (bus.addr == NIC_OUT_BUF) & ~w_out_full;
   // Router only takes a packet whose VC tag matches the current polarity
   assign w_inject   = w_out_full & bus.net_ro & (w_out_data[VC_BIT] == bus.net_polarity);

   nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_in_buf (
      .CLK     (CLK),
      .RESET   (RESET),
      .i_load  (w_in_load),
      .i_clear (w_in_clear),
      .i_data  (bus.net_di),
      .o_full  (w_in_full),
      .o_data  (w_in_data)
   );

   nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
      .CLK     (CLK),
      .RESET   (RESET),
      .i_load  (w_out_load),
      .i_clear (w_inject),
      .i_data  (bus.d_in),
      .o_full  (w_out_full),
      .o_data  (w_out_data)
   );

   always_comb begin
      w_rd_data = '0;
      if (w_rd) begin
         case (bus.addr)
            NIC_IN_BUF:   w_rd_data = w_in_data;
            NIC_IN_STAT:  w_rd_data[DATA_WIDTH-1] = w_in_full;
            NIC_OUT_STAT: w_rd_data[DATA_WIDTH-1] = w_out_full;
            default:      w_rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_net_so <= 1'b0;
         r_net_do <= '0;
      end else begin
         r_net_so <= w_inject;
         if (w_inject) begin
            r_net_do <= w_out_data;
         end
      end
   end

   assign bus.d_out  = w_rd_data;
   assign bus.net_ri = ~w_in_full;
   assign bus.net_so = r_net_so;
   assign bus.net_do = r_net_do;

endmodule

`default_nettype wire
